// File: rtl/miner_pkg.sv
// Shared miner definitions: lane/nonce defaults and the result collector state type.
// Optional build macro SHA_COLLECTOR_WATCHDOG_EN adds the TIMEDOUT state.
package miner_pkg;

  // Defaults shared with the lane array and the nonce counter
  localparam int unsigned NUM_LANES_DEF = 4;
  localparam int unsigned NONCE_W_DEF   = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_FOUND     = 3'd2,
    ST_EXHAUSTED = 3'd3
`ifdef SHA_COLLECTOR_WATCHDOG_EN
    ,
    ST_TIMEDOUT  = 3'd4
`endif
  } collector_state_t;

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-index priority encoder: NUM_LANES request bits to a LANE_W index plus an any-bit flag.
module lane_prio_enc #(
  parameter int unsigned NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0]         i_req,
  output logic [$clog2(NUM_LANES)-1:0] o_idx_c,
  output logic                         o_any_c
);

  localparam int unsigned LANE_W = $clog2(NUM_LANES);

  // Scan from the top down so the lowest set index is the one that sticks
  always_comb begin
    o_idx_c = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx_c = LANE_W'(i);
      end
    end
  end

  assign o_any_c = |i_req;

endmodule

// File: rtl/sha_result_collector.sv
// Collects per-lane done/hit flags for one mining round and returns the controller
// handshake (complete / valid / finished_validating) plus the winning lane and nonce.
// Optional build macro SHA_COLLECTOR_WATCHDOG_EN adds a COLLECT-phase watchdog.
module sha_result_collector
  import miner_pkg::*;
#(
  parameter int unsigned NUM_LANES = NUM_LANES_DEF,
  parameter int unsigned NONCE_W   = NONCE_W_DEF,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         begin_sha,
  input  logic [NONCE_W-1:0]           base_nonce,
  input  logic [NUM_LANES-1:0]         lane_done,
  input  logic [NUM_LANES-1:0]         lane_hit,
  output logic                         complete,
  output logic                         valid,
  output logic                         finished_validating,
  output logic [$clog2(NUM_LANES)-1:0] win_lane,
  output logic [NONCE_W-1:0]           win_nonce,
  output logic                         timeout
);

  localparam int unsigned LANE_W = $clog2(NUM_LANES);

  // Elaboration-time parameter sanity
  if ((NUM_LANES < 2) || (NUM_LANES > 32) || ((NUM_LANES & (NUM_LANES - 1)) != 0)) begin : g_bad_lanes
    $error("NUM_LANES must be a power of two in 2..32");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  collector_state_t r_state, w_state_nxt;

  logic [NUM_LANES-1:0] r_done_mask, w_done_mask_nxt;
  logic [NUM_LANES-1:0] w_new, w_hits, w_mask_all;
  logic [NONCE_W-1:0]   r_nonce, w_nonce_nxt;
  logic [NONCE_W-1:0]   r_win_nonce, w_win_nonce_nxt;
  logic [LANE_W-1:0]    r_win_lane, w_win_lane_nxt;
  logic [LANE_W-1:0]    w_hit_idx;
  logic                 w_hit_any;
  logic                 r_complete, w_complete_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_finished, w_finished_nxt;

`ifdef SHA_COLLECTOR_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt, w_wd_cnt_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic            w_wd_expired;

  assign w_wd_expired = (r_wd_cnt == WD_W'(TIMEOUT));
`endif

  // Lanes reporting for the first time this round, and which of them hit
  assign w_new      = lane_done & ~r_done_mask;
  assign w_hits     = w_new & lane_hit;
  assign w_mask_all = r_done_mask | w_new;

  lane_prio_enc #(
    .NUM_LANES (NUM_LANES)
  ) u_prio (
    .i_req   (w_hits),
    .o_idx_c (w_hit_idx),
    .o_any_c (w_hit_any)
  );

  // Next-state and next-output logic; begin_sha overrides everything
  always_comb begin
    w_state_nxt     = r_state;
    w_done_mask_nxt = r_done_mask;
    w_nonce_nxt     = r_nonce;
    w_win_lane_nxt  = r_win_lane;
    w_win_nonce_nxt = r_win_nonce;
    w_complete_nxt  = 1'b0;
    w_valid_nxt     = r_valid;
    w_finished_nxt  = r_finished;
`ifdef SHA_COLLECTOR_WATCHDOG_EN
    w_wd_cnt_nxt    = r_wd_cnt;
    w_timeout_nxt   = r_timeout;
`endif

    if (begin_sha) begin
      w_state_nxt     = ST_COLLECT;
      w_done_mask_nxt = '0;
      w_nonce_nxt     = base_nonce;
      w_valid_nxt     = 1'b0;
      w_finished_nxt  = 1'b0;
`ifdef SHA_COLLECTOR_WATCHDOG_EN
      w_wd_cnt_nxt    = '0;
      w_timeout_nxt   = 1'b0;
`endif
    end else begin
      case (r_state)
        ST_COLLECT: begin
          w_done_mask_nxt = w_mask_all;
          if ((r_done_mask == '0) && (w_new != '0)) begin
            w_complete_nxt = 1'b1;
          end
`ifdef SHA_COLLECTOR_WATCHDOG_EN
          w_wd_cnt_nxt = r_wd_cnt + WD_W'(1);
`endif
          if (w_hit_any) begin
            w_win_lane_nxt  = w_hit_idx;
            w_win_nonce_nxt = r_nonce + NONCE_W'(w_hit_idx);
            w_valid_nxt     = 1'b1;
            w_state_nxt     = ST_FOUND;
          end else if (&w_mask_all) begin
            w_finished_nxt = 1'b1;
            w_state_nxt    = ST_EXHAUSTED;
          end
`ifdef SHA_COLLECTOR_WATCHDOG_EN
          else if (w_wd_expired) begin
            w_finished_nxt = 1'b1;
            w_timeout_nxt  = 1'b1;
            w_state_nxt    = ST_TIMEDOUT;
            if (r_done_mask == '0) begin
              w_complete_nxt = 1'b1;
            end
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Round bookkeeping and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_done_mask <= '0;
      r_nonce     <= '0;
      r_win_lane  <= '0;
      r_win_nonce <= '0;
      r_complete  <= 1'b0;
      r_valid     <= 1'b0;
      r_finished  <= 1'b0;
    end else begin
      r_done_mask <= w_done_mask_nxt;
      r_nonce     <= w_nonce_nxt;
      r_win_lane  <= w_win_lane_nxt;
      r_win_nonce <= w_win_nonce_nxt;
      r_complete  <= w_complete_nxt;
      r_valid     <= w_valid_nxt;
      r_finished  <= w_finished_nxt;
    end
  end

`ifdef SHA_COLLECTOR_WATCHDOG_EN
  // Watchdog counter and its sticky timeout flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt  <= w_wd_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign complete            = r_complete;
  assign valid               = r_valid;
  assign finished_validating = r_finished;
  assign win_lane            = r_win_lane;
  assign win_nonce           = r_win_nonce;

endmodule
